// File: rtl/bfp_scale_ctrl.sv
// Block-floating-point scaling controller: reduces per-beat sign-bit counts over a
// stage frame into a normalisation shift and tracks the cumulative block exponent.
module bfp_scale_ctrl #(
    parameter int NUM_BEAT  = 64,
    parameter int NUM_STAGE = 9,
    parameter int GUARD     = 2,
    parameter int MAX_SHIFT = 8,
    parameter int EXPW      = 8,
    parameter int SW        = $clog2(NUM_STAGE)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr,
    input  logic            mag_valid,
    input  logic [4:0]      mag_min,
    output logic            scale_valid,
    input  logic            scale_ready,
    output logic [3:0]      scale_shift,
    output logic [SW-1:0]   scale_stage,
    output logic            scale_last,
    output logic [EXPW-1:0] blk_exp,
    output logic            ovr_err,
    output logic            busy
);
    localparam int BW  = $clog2(NUM_BEAT);
    localparam int EW1 = EXPW + 1;

    typedef enum logic { A_IDLE, A_ACC } acc_state_t;
    typedef enum logic { H_EMPTY, H_FULL } hold_state_t;

    acc_state_t  a_state;
    hold_state_t h_state;
    logic [BW-1:0]   beat_cnt;
    logic [4:0]      run_min;
    logic [SW-1:0]   stage_cnt;
    logic [EXPW-1:0] exp_acc;

    logic            complete;
    logic            load;
    logic [4:0]      frame_min;
    logic [3:0]      shift_nx;
    logic [EXPW-1:0] base;
    logic [EXPW:0]   exp_sum;
    logic [EXPW-1:0] exp_nx;

    assign complete = mag_valid && (beat_cnt == BW'(NUM_BEAT - 1));
    assign load     = complete && (h_state == H_EMPTY || scale_ready);

    always_comb begin
        frame_min = mag_min;
        if (a_state == A_ACC && run_min < mag_min)
            frame_min = run_min;
        // Compare before subtracting so no negative intermediate appears.
        shift_nx = '0;
        if (frame_min > 5'(GUARD)) begin
            if (frame_min - 5'(GUARD) > 5'(MAX_SHIFT))
                shift_nx = 4'(MAX_SHIFT);
            else
                shift_nx = 4'(frame_min - 5'(GUARD));
        end
        base    = (stage_cnt == '0) ? '0 : exp_acc;
        exp_sum = {1'b0, base} + EW1'(shift_nx);
        exp_nx  = exp_sum[EXPW] ? '1 : exp_sum[EXPW-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_state  <= A_IDLE;
            beat_cnt <= '0;
            run_min  <= '0;
        end else if (clr) begin
            a_state  <= A_IDLE;
            beat_cnt <= '0;
            run_min  <= '0;
        end else if (mag_valid) begin
            if (complete) begin
                a_state  <= A_IDLE;
                beat_cnt <= '0;
            end else begin
                a_state  <= A_ACC;
                beat_cnt <= beat_cnt + BW'(1);
                run_min  <= frame_min;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_state     <= H_EMPTY;
            scale_shift <= '0;
            scale_stage <= '0;
            scale_last  <= 1'b0;
            stage_cnt   <= '0;
            exp_acc     <= '0;
            ovr_err     <= 1'b0;
        end else if (clr) begin
            h_state     <= H_EMPTY;
            scale_shift <= '0;
            scale_stage <= '0;
            scale_last  <= 1'b0;
            stage_cnt   <= '0;
            exp_acc     <= '0;
            ovr_err     <= 1'b0;
        end else if (load) begin
            h_state     <= H_FULL;
            scale_shift <= shift_nx;
            scale_stage <= stage_cnt;
            scale_last  <= (stage_cnt == SW'(NUM_STAGE - 1));
            exp_acc     <= exp_nx;
            stage_cnt   <= (stage_cnt == SW'(NUM_STAGE - 1)) ? '0 : stage_cnt + SW'(1);
        end else begin
            if (h_state == H_FULL && scale_ready)
                h_state <= H_EMPTY;
            // Completion while full and not draining drops the result.
            if (complete)
                ovr_err <= 1'b1;
        end
    end

    assign scale_valid = (h_state == H_FULL);
    assign blk_exp     = exp_acc;
    assign busy        = (beat_cnt != '0) || scale_valid;

endmodule

// File: doc/bfp_scale_ctrl.md
# bfp_scale_ctrl

Block-floating-point scaling controller for the FFT datapath. It consumes the per-beat minimum redundant-sign-bit count from the 8-lane magnitude detector (`min_chain` / `out_valid`). It reduces that count across one full stage frame into a frame-wide headroom value and converts it into a saturated right/left normalisation shift for the next butterfly stage. It also tracks the cumulative block exponent across all stages of one transform and hands each shift to the stage sequencer over a valid/ready handshake.

## Interface
- `NUM_BEAT`, 64: `mag_valid` beats per stage frame (512 points / 8 lanes).
- `NUM_STAGE`, 9: stage frames per transform.
- `GUARD`, 2: headroom bits reserved for next-stage growth.
- `MAX_SHIFT`, 8: maximum shift per stage.
- `EXPW`, 8: block-exponent width.

- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear of all state; priority over all other inputs.
- `mag_valid` in 1: `mag_min` is valid this cycle.
- `mag_min` in 5: minimum redundant-sign count of one 8-lane beat (0..24).
- `scale_valid` out 1: holding register contains a result.
- `scale_ready` in 1: consumer accepts the result when `scale_valid` and `scale_ready` are both high.
- `scale_shift` out 4: normalisation shift for the next stage.
- `scale_stage` out $clog2(NUM_STAGE): stage index of the held result.
- `scale_last` out 1: held result is stage `NUM_STAGE-1`.
- `blk_exp` out EXPW: cumulative shift of stages 0..`scale_stage` inclusive.
- `ovr_err` out 1: sticky overrun flag.
- `busy` out 1: `beat_cnt != 0` or `scale_valid`.

## Operation
- Accumulator FSM:
  - A_IDLE (`beat_cnt`=0): a `mag_valid` beat loads `run_min = mag_min`, sets `beat_cnt` to 1 and moves to A_ACC.
  - A_ACC: each `mag_valid` beat sets `run_min = min(run_min, mag_min)` and increments `beat_cnt`.
  - Cycles with `mag_valid` low are ignored entirely, whatever `mag_min` holds.
- Frame completion: a `mag_valid` beat with `beat_cnt == NUM_BEAT-1`.
  - `frame_min = min(run_min, mag_min)`.
  - `beat_cnt` returns to 0 and the FSM returns to A_IDLE.
- Shift rule: `scale_shift = (frame_min <= GUARD) ? 0 : min(frame_min - GUARD, MAX_SHIFT)`. Unsigned arithmetic; no negative intermediate is formed.
- Holding register, states H_EMPTY and H_FULL:
  - On frame completion with H_EMPTY, or with H_FULL and `scale_ready` high in the same cycle:
    - load `scale_shift`;
    - set `scale_stage` = `stage_cnt`;
    - set `blk_exp` = (`stage_cnt`==0 ? 0 : `exp_acc`) + shift, saturating at all-ones;
    - `exp_acc` takes the new `blk_exp`;
    - `stage_cnt` increments, wrapping from `NUM_STAGE-1` to 0;
    - go to or stay in H_FULL.
  - Handshake with no completion in the same cycle: H_FULL → H_EMPTY.
  - Frame completion with H_FULL and `scale_ready` low (overrun):
    - the new result is discarded;
    - `stage_cnt`, `exp_acc` and the held outputs are unchanged;
    - `ovr_err` is set and stays set until `clr` or reset.
- Held outputs stay stable while `scale_valid` is high and `scale_ready` is low.
- `clr` and reset:
  - `beat_cnt`, `run_min`, `stage_cnt`, `exp_acc` and `ovr_err` go to 0; holding register goes to H_EMPTY.
  - Any partial frame is discarded; the next `mag_valid` beat starts a new frame at stage 0.

## Timing
- Reset values: `scale_valid`=0, `scale_shift`=0, `scale_stage`=0, `scale_last`=0, `blk_exp`=0, `ovr_err`=0, `busy`=0.
- Latency: `scale_valid` rises on the first rising edge after the completing beat.
  - Held outputs are registered.
  - No combinational path from `mag_valid`/`mag_min` to any output.
- `scale_last` is a registered decode of the held `scale_stage`.
- Back-to-back frames with no idle beats are sustained whenever `scale_ready` is high on completion cycles.
- `mag_valid` may stay high continuously; throughput is 1 beat per clock.
- `scale_ready` is sampled only while `scale_valid` is high.

## Test plan
- Reset, then 64 beats with `mag_min`=5 and `scale_ready`=1:
  - the cycle after beat 63: `scale_valid`=1, `scale_shift`=3, `scale_stage`=0, `blk_exp`=3, `ovr_err`=0.
- Saturation and clamping:
  - 63 beats at 20 plus one beat at 1 → `scale_shift`=0.
  - all 64 beats at 24 → `scale_shift`=8.
  - all 64 beats at 2 → `scale_shift`=0.
- Full transform, 9 frames of all-5 with `scale_ready`=1:
  - `blk_exp` = 3, 6, …, 27; `scale_last`=1 only at stage 8.
  - a 10th frame reports `scale_stage`=0 and `blk_exp`=3.
- Backpressure:
  - `scale_ready`=0 while frame 2 completes → `ovr_err`=1; held values stay those of stage 0.
  - Rerun with `scale_ready` pulsed exactly on the frame-2 completion cycle → `ovr_err`=0; stage 1 loads and `scale_valid` stays 1.
- Gapped input:
  - 64 valid beats at 6 interleaved with random idle cycles carrying `mag_min`=0 → `scale_shift`=4; the idle zeros do not affect the result.
- Mid-frame clear and reset:
  - 30 beats, then `clr`, then 64 beats at 7 → a single result: `scale_shift`=5, `scale_stage`=0, `busy`=0 after the handshake.
  - Repeat with `rstn` asserted mid-frame → all outputs at reset values immediately.
